// File: rtl/mux6_rr_sched_pkg.sv
// mux6_pkg: shared constants, slot state encoding and the 5->0 index wrap for the six-way scheduler
package mux6_pkg;
  localparam int NREQ = 6;
  localparam int IDX_W = 3;
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
  endfunction
endpackage

// File: rtl/mux6_rr_sched_rr_pick6.sv
// rr_pick6: combinational round-robin pick; in req[5:0], ptr[2:0] (first index scanned); out win[2:0], found (any req)
module rr_pick6
  import mux6_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             found
);
  logic [IDX_W-1:0] idx;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
  end
endmodule

// File: rtl/mux6_rr_sched.sv
// mux6_rr_sched: round-robin 6:1 W-bit mux into one valid/ready slot; in clk, resetn, req, data0..5, out_ready; out ack, sel, gnt, out, out_valid
module mux6_rr_sched
  import mux6_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic [W-1:0]     data0,
  input  logic [W-1:0]     data1,
  input  logic [W-1:0]     data2,
  input  logic [W-1:0]     data3,
  input  logic [W-1:0]     data4,
  input  logic [W-1:0]     data5,
  output logic [NREQ-1:0]  ack,
  output logic [IDX_W-1:0] sel,
  output logic [NREQ-1:0]  gnt,
  output logic [W-1:0]     out,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [0:0]       st;
  logic [IDX_W-1:0] ptr, win;
  logic             found, load;
  logic [W-1:0]     mux_d;
  rr_pick6 u_pick (.req(req), .ptr(ptr), .win(win), .found(found));
  assign out_valid = (st == S_FULL);
  assign load = resetn && found && (!out_valid || out_ready);
  assign ack = load ? NREQ'(1) << win : '0;
  always_comb begin
    mux_d = (win == 3'd0) ? data0 :
            (win == 3'd1) ? data1 :
            (win == 3'd2) ? data2 :
            (win == 3'd3) ? data3 :
            (win == 3'd4) ? data4 : data5;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st <= S_EMPTY;
      out <= '0;
      sel <= '0;
      gnt <= '0;
      ptr <= '0;
    end else if (load) begin
      st <= S_FULL;
      out <= mux_d;
      sel <= win;
      gnt <= ack;
      ptr <= next_idx(win);
    end else if (out_valid && out_ready) begin
      st <= S_EMPTY;
      gnt <= '0;
    end
  end
endmodule

// File: tb/tb_mux6_rr_sched.sv
// tb_mux6_rr_sched: directed stimulus with a scoreboard queue popped by a handshake monitor
module tb_mux6_rr_sched;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic out_ready = 1'b0;
  logic [5:0] req = '0;
  logic [5:0] ack, gnt;
  logic [3:0] data0, data1, data2, data3, data4, data5, out;
  logic [2:0] sel;
  logic out_valid;
  int checks = 0;
  int failures = 0;
  logic [6:0] sb[$];
  always #5 clk = ~clk;
  mux6_rr_sched #(.W(4)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4), .data5(data5),
    .ack(ack), .sel(sel), .gnt(gnt), .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [5:0] r, input logic [2:0] s, input logic [3:0] d);
    logic [5:0] one;
    one = 6'b000001;
    req = r;
    #1;
    chk("ack", ack, one << s);
    sb.push_back({s, d});
    tick;
    chk("out_valid_after_load", out_valid, 1);
    chk("sel_after_load", sel, s);
  endtask
  always @(negedge clk) begin
    logic [6:0] e;
    logic [5:0] one;
    one = 6'b000001;
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: got sel=%0d out=%0h expected no transfer", sel, out);
      end else begin
        e = sb.pop_front();
        chk("xfer_sel_out", {sel, out}, e);
        chk("xfer_gnt", gnt, one << e[6:4]);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    data0 = 4'd8; data1 = 4'd9; data2 = 4'd10; data3 = 4'd11; data4 = 4'd12; data5 = 4'd13;
    req = 6'h3F;
    out_ready = 1'b1;
    resetn = 1'b0;
    tick;
    #1;
    chk("rst_ack", ack, 6'h00);
    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gnt", gnt, 6'h00);
    chk("rst_sel", sel, 0);
    chk("rst_out", out, 0);
    chk("rst_ack2", ack, 6'h00);
    resetn = 1'b1;
    for (int k = 0; k < 7; k++) load(6'h3F, 3'(k % 6), 4'(8 + k % 6));
    chk("seq_out_wrap", out, 4'd8);
    load(6'b010000, 3'd4, 4'd12);
    load(6'b000011, 3'd0, 4'd8);
    load(6'b000011, 3'd1, 4'd9);
    data3 = 4'hA;
    load(6'b001000, 3'd3, 4'hA);
    out_ready = 1'b0;
    req = 6'b100000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ack", ack, 6'h00);
      tick;
      chk("bp_out", out, 4'hA);
      chk("bp_sel", sel, 3);
      chk("bp_gnt", gnt, 6'b001000);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    load(6'b100000, 3'd5, 4'd13);
    chk("bp_out_after", out, 4'd13);
    req = 6'h00;
    tick;
    chk("drain_valid", out_valid, 0);
    chk("drain_gnt", gnt, 6'h00);
    chk("drain_sel_hold", sel, 5);
    chk("drain_out_hold", out, 4'd13);
    #1;
    chk("idle_ack", ack, 6'h00);
    tick;
    chk("idle_valid", out_valid, 0);
    load(6'b000100, 3'd2, 4'd10);
    chk("single_out", out, 4'd10);
    req = 6'b010000;
    #1;
    chk("pre_rst_ack", ack, 6'b010000);
    tick;
    chk("pre_rst_sel", sel, 4);
    chk("pre_rst_valid", out_valid, 1);
    out_ready = 1'b0;
    resetn = 1'b0;
    req = 6'b010001;
    #1;
    chk("mid_rst_ack", ack, 6'h00);
    tick;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_gnt", gnt, 6'h00);
    chk("mid_rst_out", out, 0);
    resetn = 1'b1;
    out_ready = 1'b1;
    load(6'b010001, 3'd0, 4'd8);
    load(6'b010001, 3'd4, 4'd12);
    req = 6'h00;
    tick;
    tick;
    chk("end_valid", out_valid, 0);
    chk("sb_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
